// File: rtl/dbnc_pkg.sv
// dbnc_pkg: shared constants and configuration checks for the debouncer family
package dbnc_pkg;

    localparam int DBNC_CNT_W_50M = 17;
    localparam int HOLD_1S_50M    = 50_000_000;
    localparam int NCH_MAX        = 32;
    localparam int CNT_W_MAX      = 32;
    localparam int HOLD_CYC_MIN   = 1;

    function automatic bit fits_w(input longint unsigned v, input int w);
        return $clog2(v + 64'd1) <= w;
    endfunction

    // Repeat reloads hcnt to HOLD_CYC-RPT_CYC, so RPT_CYC may not exceed HOLD_CYC
    function automatic bit hold_cfg_ok(input longint unsigned hold, input longint unsigned rpt, input int w);
        return hold >= HOLD_CYC_MIN && fits_w(hold, w) && fits_w(rpt, w) && rpt <= hold;
    endfunction

endpackage

// File: rtl/dbnc_chan.sv
// dbnc_chan: one debounced channel with sync, edge pulses, hold and auto-repeat
module dbnc_chan
    import dbnc_pkg::*;
#(
    parameter int          CNT_W    = DBNC_CNT_W_50M,
    parameter logic        ACT_LOW  = 1'b0,
    parameter int          HOLD_W   = 26,
    parameter int unsigned HOLD_CYC = HOLD_1S_50M,
    parameter int unsigned RPT_CYC  = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic hw_in,
    output logic state,
    output logic closed,
    output logic open,
    output logic held,
    output logic hold_pls
);

    localparam bit                CFG_OK      = hold_cfg_ok(HOLD_CYC, RPT_CYC, HOLD_W);
    localparam bit                RPT_EN      = CFG_OK && RPT_CYC != 0;
    localparam logic [CNT_W-1:0]  CNT_MAX     = '1;
    localparam logic [HOLD_W-1:0] HCNT_MAX    = '1;
    localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(HOLD_CYC - 1);
    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_CYC - RPT_CYC);

    logic              sync0, sync1;
    logic [CNT_W-1:0]  cnt;
    logic [HOLD_W-1:0] hcnt;
    logic              diff, flip, fall, onset;

    always_comb begin
        diff  = sync1 ^ state;
        flip  = diff && cnt == CNT_MAX;
        fall  = flip && state;
        onset = state && hcnt == HOLD_LAST;
    end

    // A release on the same edge as a due repeat suppresses the pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync0    <= 1'b0;
            sync1    <= 1'b0;
            cnt      <= '0;
            state    <= 1'b0;
            closed   <= 1'b0;
            open     <= 1'b0;
            hcnt     <= '0;
            held     <= 1'b0;
            hold_pls <= 1'b0;
        end else begin
            sync0    <= hw_in ^ ACT_LOW;
            sync1    <= sync0;
            cnt      <= (diff && !flip) ? cnt + 1'b1 : '0;
            state    <= state ^ flip;
            closed   <= flip && !state;
            open     <= fall;
            held     <= !fall && (held || onset);
            hold_pls <= onset && !fall;
            hcnt     <= (fall || !state) ? '0 :
                        (onset && RPT_EN) ? HOLD_RELOAD :
                        (hcnt == HCNT_MAX) ? hcnt : hcnt + 1'b1;
        end
    end

endmodule

// File: rtl/dbnc_multi.sv
// dbnc_multi: NCH independent debounced button/switch channels
module dbnc_multi
    import dbnc_pkg::*;
#(
    parameter int             NCH      = 4,
    parameter int             CNT_W    = DBNC_CNT_W_50M,
    parameter logic [NCH-1:0] ACT_LOW  = '0,
    parameter int             HOLD_W   = 26,
    parameter int unsigned    HOLD_CYC = HOLD_1S_50M,
    parameter int unsigned    RPT_CYC  = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] hw_in,
    output logic [NCH-1:0] state,
    output logic [NCH-1:0] closed,
    output logic [NCH-1:0] open,
    output logic [NCH-1:0] held,
    output logic [NCH-1:0] hold_pls
);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        dbnc_chan #(
            .CNT_W   (CNT_W),
            .ACT_LOW (ACT_LOW[i]),
            .HOLD_W  (HOLD_W),
            .HOLD_CYC(HOLD_CYC),
            .RPT_CYC (RPT_CYC)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .hw_in   (hw_in[i]),
            .state   (state[i]),
            .closed  (closed[i]),
            .open    (open[i]),
            .held    (held[i]),
            .hold_pls(hold_pls[i])
        );
    end

endmodule

// File: tb/tb_dbnc_multi.sv
// tb_dbnc_multi: directed checks of debounce, pulses, hold/repeat, polarity and reset
module tb_dbnc_multi;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] hw_in = 2'b10;
    logic [1:0] state, closed, open, held, hold_pls;
    int         checks = 0;
    int         failures = 0;

    dbnc_multi #(
        .NCH(2), .CNT_W(4), .ACT_LOW(2'b10), .HOLD_W(8), .HOLD_CYC(40), .RPT_CYC(10)
    ) dut (
        .clk(clk), .rst(rst), .hw_in(hw_in), .state(state), .closed(closed),
        .open(open), .held(held), .hold_pls(hold_pls)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {state, closed, open, held, hold_pls}, 32'h0);
    endtask

    initial begin
        int extra;
        logic quiet;
        #2 rst = 1'b1;
        #1 check_all_zero("reset_async");
        step(3);
        check_all_zero("reset_held");
        rst = 1'b0;

        // clean press on ch0, ch1 idle (active low, hw_in[1]=1)
        hw_in = 2'b11;
        step(17);
        check("press_st_pre", state, 2'b00);
        check("press_cl_pre", closed, 2'b00);
        step(1);
        check("press_st", state, 2'b01);
        check("press_cl", closed, 2'b01);
        check("press_op", open, 2'b00);
        step(1);
        check("press_cl_end", closed, 2'b00);

        // hold onset at E+40, repeats every 10 cycles
        step(38);
        check("hold_pre", {held, hold_pls}, 4'b0000);
        step(1);
        check("hold_on", {held, hold_pls}, 4'b0101);
        step(1);
        check("hold_pls_end", {held, hold_pls}, 4'b0100);
        step(8);
        check("rpt_pre", hold_pls, 2'b00);
        step(1);
        check("rpt1", hold_pls, 2'b01);
        step(10);
        check("rpt2", hold_pls, 2'b01);

        // release timed so the fall coincides with a due repeat at E+80
        step(2);
        hw_in = 2'b10;
        step(8);
        check("rpt3", hold_pls, 2'b01);
        step(9);
        check("rel_pre", {state, open}, 4'b0100);
        step(1);
        check("rel_st", state, 2'b00);
        check("rel_open", open, 2'b01);
        check("rel_held", held, 2'b00);
        check("rel_no_rpt", hold_pls, 2'b00);
        step(1);
        check("rel_open_end", open, 2'b00);
        step(10);
        check("rel_quiet", {held, hold_pls}, 4'b0000);

        // bounce: toggle every 5 cycles for 40 cycles, then stay pressed
        quiet = 1'b1;
        for (int k = 0; k < 8; k++) begin
            hw_in[0] = (k % 2 == 0);
            for (int c = 0; c < 5; c++) begin
                step(1);
                if (state != 2'b00 || closed != 2'b00) quiet = 1'b0;
            end
        end
        check("bounce_quiet", quiet, 1'b1);
        hw_in[0] = 1'b1;
        step(17);
        check("bounce_st_pre", state, 2'b00);
        step(1);
        check("bounce_st", state, 2'b01);
        check("bounce_cl", closed, 2'b01);
        extra = 0;
        for (int c = 0; c < 20; c++) begin
            step(1);
            if (closed != 2'b00) extra++;
        end
        check("bounce_one_pulse", extra, 0);

        // active-low ch1 pressed by driving 0
        hw_in = 2'b01;
        step(17);
        check("al_st_pre", state, 2'b01);
        step(1);
        check("al_st", state, 2'b11);
        check("al_cl", closed, 2'b10);

        // reset mid-debounce with ch1 pressed and ch0 being pressed
        hw_in = 2'b00;
        step(20);
        check("rs_ch0_rel", state, 2'b10);
        hw_in = 2'b01;
        step(10);
        rst = 1'b1;
        #1 check_all_zero("rs_async");
        step(2);
        check_all_zero("rs_held");
        rst = 1'b0;
        step(17);
        check("rs_st_pre", state, 2'b00);
        step(1);
        check("rs_st", state, 2'b11);
        check("rs_cl", closed, 2'b11);

        // simultaneous release then simultaneous press
        hw_in = 2'b10;
        step(18);
        check("sim_open", {state, open}, 4'b0011);
        step(5);
        hw_in = 2'b01;
        step(17);
        check("sim_cl_pre", closed, 2'b00);
        step(1);
        check("sim_cl", closed, 2'b11);
        check("sim_st", state, 2'b11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
